// File: rtl/softmax_row_stream.sv
// softmax_row_stream
// Row-streaming softmax. Score elements arrive one per cycle on a valid/ready
// stream, with in_last closing the row. Each row is buffered, the row max is
// tracked, and then every element is turned into a base-2 exponential
// approximation of (x - max). The results are summed and normalised, and the
// normalised row is streamed out with backpressure.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready only in LOAD)
//   in_data, in_last    signed Q.FRAC_BITS score, end-of-row marker
//   out_valid/out_ready output handshake
//   out_data, out_last  unsigned Q.FRAC_BITS probability, end-of-row marker
//   busy                high while exponentiating or normalising
//   err_overflow        one-cycle pulse when a row is cut at MAX_LEN
//
// state | meaning
// ------+----------------------------------------------------------
// LOAD  | accept elements into row_buf, track running max
// EXP   | one element per cycle: e = 2^-(d*log2e), accumulate sum
// NORM  | stream e/sum, one element per out handshake

module softmax_row_stream #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int MAX_LEN      = 64,
  parameter int FRAC_BITS    = 14,
  parameter int LOG2E_Q      = 23637
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_overflow
);

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int E_W    = FRAC_BITS + 1;
  localparam int SUM_W  = FRAC_BITS + 1 + $clog2(MAX_LEN);
  // d needs INPUT_WIDTH+1 bits; LOG2E_Q is treated as a 32-bit constant.
  localparam int PROD_W = INPUT_WIDTH + 1 + 32;
  localparam int NUM_W  = E_W + FRAC_BITS;
  localparam int DIV_W  = (NUM_W > SUM_W) ? NUM_W : SUM_W;
  localparam int SAT_W  = DIV_W + OUTPUT_WIDTH;

  localparam logic [E_W-1:0]                ONE_E   = E_W'(1) << FRAC_BITS;
  localparam logic signed [INPUT_WIDTH-1:0] MIN_VAL = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0]       OUT_MAX = '1;

  typedef enum logic [1:0] {S_LOAD, S_EXP, S_NORM} state_t;

  state_t state, next_state;

  logic [IDX_W-1:0]              count;
  logic [IDX_W-1:0]              last_idx;
  logic [IDX_W-1:0]              j;
  logic [IDX_W-1:0]              j_next;
  logic signed [INPUT_WIDTH-1:0] max_val;
  logic [SUM_W-1:0]              sum;
  logic [INPUT_WIDTH-1:0]        row_buf [MAX_LEN];
  logic [E_W-1:0]                ebuf    [MAX_LEN];

  logic                          in_fire;
  logic                          out_fire;
  logic                          row_end;
  logic                          at_cap;

  logic [INPUT_WIDTH-1:0]        cur;
  logic signed [INPUT_WIDTH:0]   d_ext;
  logic [PROD_W-1:0]             prod;
  logic [PROD_W-1:0]             t_val;
  logic [PROD_W-1:0]             k_val;
  logic [FRAC_BITS-1:0]          f_val;
  logic [E_W-1:0]                mant;
  logic [E_W-1:0]                e_shift;
  logic [E_W-1:0]                e_val;

  logic [E_W-1:0]                div_e;
  logic [SUM_W-1:0]              div_sum;
  logic [NUM_W-1:0]              num;
  logic [DIV_W-1:0]              quot;
  logic [SAT_W-1:0]              q_ext;
  logic [OUTPUT_WIDTH-1:0]       norm_val;

  assign in_ready = (state == S_LOAD) && !rst;
  assign busy     = (state != S_LOAD);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign at_cap   = (count == IDX_W'(MAX_LEN - 1));
  assign row_end  = in_fire && (in_last || at_cap);
  assign j_next   = (j == last_idx) ? '0 : j + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LOAD: if (row_end) next_state = S_EXP;
      S_EXP:  if (j == last_idx) next_state = S_NORM;
      S_NORM: if (out_fire && out_last) next_state = S_LOAD;
      default: next_state = S_LOAD;
    endcase
  end

  // Base-2 exponential of -(max - x): split d*log2(e) into integer k and
  // fraction f, approximate 2^-f by 1 - f/2, then shift right by k.
  // The result is floored at 1 so no element ever contributes zero.
  always_comb begin
    cur     = row_buf[j];
    d_ext   = $signed({max_val[INPUT_WIDTH-1], max_val}) - $signed({cur[INPUT_WIDTH-1], cur});
    prod    = PROD_W'($unsigned(d_ext)) * PROD_W'(LOG2E_Q);
    t_val   = prod >> FRAC_BITS;
    k_val   = t_val >> FRAC_BITS;
    f_val   = t_val[FRAC_BITS-1:0];
    mant    = ONE_E - E_W'(f_val >> 1);
    e_shift = mant >> k_val;
    if (k_val > PROD_W'(FRAC_BITS) || e_shift == '0) e_val = E_W'(1);
    else                                             e_val = e_shift;
  end

  // One divider feeds the output register. On the last EXP cycle, sum and
  // ebuf have not been updated yet, so the pending values are forwarded.
  always_comb begin
    if (state == S_EXP) begin
      div_e   = (last_idx == '0) ? e_val : ebuf[0];
      div_sum = sum + SUM_W'(e_val);
    end else begin
      div_e   = ebuf[j_next];
      div_sum = sum;
    end
    num      = {div_e, {FRAC_BITS{1'b0}}};
    quot     = DIV_W'(num) / DIV_W'(div_sum);
    q_ext    = SAT_W'(quot);
    norm_val = (q_ext > SAT_W'(OUT_MAX)) ? OUT_MAX : q_ext[OUTPUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_fire) row_buf[count] <= in_data;
    if (state == S_EXP && !rst)     ebuf[j]        <= e_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      last_idx     <= '0;
      j            <= '0;
      max_val      <= MIN_VAL;
      sum          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            if ($signed(in_data) > max_val) max_val <= $signed(in_data);
            if (row_end) begin
              last_idx     <= count;
              j            <= '0;
              err_overflow <= !in_last;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_EXP: begin
          sum <= sum + SUM_W'(e_val);
          if (j == last_idx) begin
            j         <= '0;
            out_valid <= 1'b1;
            out_data  <= norm_val;
            out_last  <= (last_idx == '0);
          end else begin
            j <= j + 1'b1;
          end
        end
        S_NORM: begin
          if (out_fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              sum       <= '0;
              count     <= '0;
              j         <= '0;
              max_val   <= MIN_VAL;
            end else begin
              j        <= j_next;
              out_data <= norm_val;
              out_last <= (j_next == last_idx);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/softmax_row_stream.md
Name: softmax_row_stream

Overview:
- Row-streaming softmax engine for the attention datapath; successor to the full-matrix softmax block.
- Accepts score rows one element per cycle over a valid/ready stream and buffers up to MAX_LEN elements per row.
- Computes a numerically stable softmax per row: subtracts the row max, then applies a base-2 exponential approximation, sums, and normalises.
- Emits the normalised row on a valid/ready stream with backpressure. Row length is variable at run time and is delimited by in_last.

Parameters:
- INPUT_WIDTH, 32, signed score width, fixed point with FRAC_BITS fractional bits.
- OUTPUT_WIDTH, 32, unsigned probability width, fixed point with FRAC_BITS fractional bits.
- MAX_LEN, 64, maximum row length (row buffer depth), at least 1.
- FRAC_BITS, 14, fractional bits; ONE = 1<<FRAC_BITS.
- LOG2E_Q, 23637, log2(e) in Q.FRAC_BITS; the default is for FRAC_BITS=14.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an input element
- in_data  in  INPUT_WIDTH  signed score
- in_last  in  1  marks the final element of a row
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts
- out_data  out  OUTPUT_WIDTH  softmax value
- out_last  out  1  marks the final output of a row
- busy  out  1  high in EXP or NORM
- err_overflow  out  1  one-cycle pulse when a row is truncated at MAX_LEN

Behaviour:
- Reset: this is one clock domain. rst is synchronous and active-high. rst has priority over all activity, including mid-row; the partial row is discarded.
- Reset values: state=LOAD, count=0, max=most-negative, sum=0, out_valid=0, out_data=0, out_last=0, err_overflow=0, busy=0.
- in_ready is combinational: in_ready = (state==LOAD) and not rst.
- LOAD state:
  - On in_valid&&in_ready: buf[count]<=in_data; max<=signed max(max,in_data); count++.
  - If in_last is set, or count==MAX_LEN-1, go to EXP with len=count+1 and j=0.
  - If the row is terminated at MAX_LEN without in_last, pulse err_overflow for 1 cycle. Any subsequent elements belong to the next row.
- EXP state: one element per cycle, j=0..len-1.
  - d = max - buf[j], unsigned, always >= 0.
  - t = (d*LOG2E_Q)>>FRAC_BITS. Use a product width sufficient with no overflow.
  - k = t>>FRAC_BITS; f = t & (ONE-1).
  - e = (ONE - (f>>1)) >> k. If k > FRAC_BITS or e==0, then e=1 (floor, never zero).
  - ebuf[j]<=e; sum<=sum+e. sum width is FRAC_BITS+1+clog2(MAX_LEN).
  - On j==len-1: go to NORM with j=0, and load the first output register.
  - sum >= ONE always, because the max element gives e=ONE, so no divide-by-zero path exists.
- NORM state:
  - out_data = (ebuf[j]<<FRAC_BITS)/sum, truncating, saturated to 2^OUTPUT_WIDTH-1.
  - out_valid=1; out_last=(j==len-1).
  - out_data and out_last are registered. They are held stable while out_valid&&!out_ready.
  - On handshake: j++ and the next value is registered the same cycle, so there are no bubbles.
  - On the handshake of out_last: out_valid<=0, out_last<=0, sum<=0, count<=0, max<=most-negative, state<=LOAD.
- Timing: LOAD takes L cycles at full rate and EXP takes L cycles. The first out_valid is asserted the cycle after the last EXP cycle. Throughput is 3L cycles per row.
- Single-element row (in_last on the first element): output is exactly ONE.
- Equal elements: each output is floor(ONE/L).
- Inputs presented while not in LOAD are ignored, since in_ready=0.

Test Plan:
- Row [0,0,0,0] with in_last on the 4th element, out_ready=1 → four outputs of 4096. out_last is set on the 4th output. The first out_valid is 5 cycles after the last input handshake.
- Row [0, -16384] (0.0 and -1.0) → e values 16384 and 6379, sum 22763, outputs 11792 then 4591.
- Row [16384, 0] (max subtraction check, shifted copy of the previous row) → outputs 11792 then 4591, identical to the previous row.
- Row [0, -98304] (d=6.0) → e2=43, outputs 16341 then 42. Row [0, most-negative] → e2 floored to 1, outputs 16383 then 0.
- 65 elements without in_last at MAX_LEN=64 → the row closes after 64 elements and err_overflow pulses once. The 65th element starts the next row. Toggle out_ready randomly: out_data must be held stable while stalled and no value may be lost.
- Assert rst mid-EXP and mid-NORM → next cycle out_valid=0, busy=0, in_ready=1. A fresh single-element row then yields 16384.
